// File: rtl/alu_pkg.sv
// Shared ALU encodings and bus types for the EX-stage ALU issue path.
package alu_pkg;
    localparam int ALU_W    = 32;
    localparam int ALU_OP_W = 3;

    localparam logic [ALU_OP_W-1:0] ALU_OP_AND = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR  = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 3'b110;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLT = 3'b111;

    typedef struct packed {
        logic [ALU_W-1:0]    a;
        logic [ALU_W-1:0]    b;
        logic [ALU_OP_W-1:0] op;
    } alu_opnd_t;

    typedef struct packed {
        logic [ALU_W-1:0] data;
        logic             zero;
    } alu_rsp_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: scans ptr+1, ptr+2, ... and picks the first active request.
// Purely combinational (0 cycles); en=0 forces all grants low, winner/any still reflect the scan.
module rr_arbiter #(
    parameter int N    = 2,
    parameter int ID_W = 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] winner,
    output logic            any
);
    int idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = ID_W'(idx);
            end
        end
        if (en && any) begin
            grant[winner] = 1'b1;
        end
    end
endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of N_REQ requesters into a shared ALU: S1 operands -> ALU -> S2 response, 1 op/cycle, 2-cycle latency.
// Stalled S2 (rsp_valid & ~rsp_ready) holds S1 when full and drops all req_ready; flush empties both stages.
module alu_issue_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*ALU_W-1:0]    req_a,
    input  logic [N_REQ*ALU_W-1:0]    req_b,
    input  logic [N_REQ*ALU_OP_W-1:0] req_op,
    output logic [ALU_W-1:0]          alu_a,
    output logic [ALU_W-1:0]          alu_b,
    output logic [ALU_OP_W-1:0]       alu_op,
    input  logic [ALU_W-1:0]          alu_result,
    input  logic                      alu_zero,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [ALU_W-1:0]          rsp_data,
    output logic                      rsp_zero
);
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] s1_id;
    logic            s1_valid;
    alu_opnd_t       s1;
    alu_opnd_t       win_opnd;
    alu_rsp_t        s2;

    logic            s2_load;
    logic            s1_free;
    logic            grant_en;
    logic            accept;
    logic            any_req;
    logic [ID_W-1:0] winner;

    assign s2_load  = s1_valid & (~rsp_valid | rsp_ready);
    assign s1_free  = ~s1_valid | s2_load;
    // rst_n gates the grant so no requester sees a handshake while the block is held in reset.
    assign grant_en = s1_free & ~flush & rst_n;
    assign accept   = grant_en & any_req;

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .req    (req_valid),
        .ptr    (ptr),
        .en     (grant_en),
        .grant  (req_ready),
        .winner (winner),
        .any    (any_req)
    );

    always_comb begin
        win_opnd    = '0;
        win_opnd.a  = req_a[ALU_W*int'(winner) +: ALU_W];
        win_opnd.b  = req_b[ALU_W*int'(winner) +: ALU_W];
        win_opnd.op = req_op[ALU_OP_W*int'(winner) +: ALU_OP_W];
    end

    // S1: operand register driving the ALU directly; data holds when the stage empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1       <= '0;
            s1_id    <= '0;
            ptr      <= ID_W'(N_REQ - 1);
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1       <= win_opnd;
            s1_id    <= winner;
            ptr      <= winner;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // S2: response register capturing the ALU output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            s2        <= '0;
            rsp_id    <= '0;
        end else if (flush) begin
            rsp_valid <= 1'b0;
        end else if (s2_load) begin
            rsp_valid <= 1'b1;
            s2.data   <= alu_result;
            s2.zero   <= alu_zero;
            rsp_id    <= s1_id;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign alu_a    = s1.a;
    assign alu_b    = s1.b;
    assign alu_op   = s1.op;
    assign rsp_data = s2.data;
    assign rsp_zero = s2.zero;
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter with N_REQ=2 and a behavioural ALU.
module tb_alu_issue_arbiter;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [5:0]  req_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_zero;

    int n_checks;
    int n_fail;

    alu_issue_arbiter #(.N_REQ(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            ALU_OP_AND: alu_result = alu_a & alu_b;
            ALU_OP_OR:  alu_result = alu_a | alu_b;
            ALU_OP_ADD: alu_result = alu_a + alu_b;
            ALU_OP_SUB: alu_result = alu_a - alu_b;
            ALU_OP_SLT: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default:    alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        req_valid[i]       = v;
        req_a[32*i +: 32]  = a;
        req_b[32*i +: 32]  = b;
        req_op[3*i +: 3]   = op;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
        req_valid = 2'b11; req_a = '0; req_b = '0; req_op = '0;
        #2;
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        n_checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 3'd0) begin n_fail++; $display("FAIL reset_alu got=%h/%h/%h exp=0/0/0", alu_a, alu_b, alu_op); end
        n_checks++; if (rsp_data !== 32'd0 || rsp_zero !== 1'b0 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp got=%h/%b/%b exp=0/0/0", rsp_data, rsp_zero, rsp_id); end
        req_valid = 2'b00;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        set_req(0, 1'b1, 32'd5, 32'd7, ALU_OP_ADD);
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_grant got=%b exp=01", req_ready); end
        tick();
        req_valid = 2'b00;
        n_checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_op !== ALU_OP_ADD) begin n_fail++; $display("FAIL single_alu got=%0d/%0d/%b exp=5/7/010", alu_a, alu_b, alu_op); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_early got=%b exp=0", rsp_valid); end
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd12 || rsp_id !== 1'b0 || rsp_zero !== 1'b0) begin n_fail++; $display("FAIL single_rsp got=v%b d%0d id%0d z%b exp=v1 d12 id0 z0", rsp_valid, rsp_data, rsp_id, rsp_zero); end
        tick();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got=%b exp=0", rsp_valid); end
    endtask

    // Pointer sits at 0 after the single op, so requester 1 wins first.
    task automatic test_contention();
        logic [0:0]  exp_id  [0:7];
        logic [31:0] exp_dat [0:7];
        for (int c = 0; c < 9; c++) begin
            if (c < 6) begin
                set_req(0, 1'b1, 32'd100 + 32'(c), 32'd0, ALU_OP_ADD);
                set_req(1, 1'b1, 32'd200 + 32'(c), 32'd1, ALU_OP_ADD);
                exp_id[c]  = (c % 2 == 0) ? 1'b1 : 1'b0;
                exp_dat[c] = (c % 2 == 0) ? 32'd201 + 32'(c) : 32'd100 + 32'(c);
                #1;
                n_checks++; if (req_ready !== (2'b01 << exp_id[c])) begin n_fail++; $display("FAIL contention_grant c=%0d got=%b exp_id=%0d", c, req_ready, exp_id[c]); end
            end else begin
                req_valid = 2'b00;
            end
            if (c >= 2 && c < 8) begin
                n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id[c-2] || rsp_data !== exp_dat[c-2]) begin n_fail++; $display("FAIL contention_rsp c=%0d got=v%b id%0d d%0d exp=v1 id%0d d%0d", c, rsp_valid, rsp_id, rsp_data, exp_id[c-2], exp_dat[c-2]); end
            end
            if (c == 8) begin
                n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL contention_drain got=%b exp=0", rsp_valid); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 32'd10, 32'd1, ALU_OP_ADD);
        set_req(1, 1'b1, 32'd20, 32'd2, ALU_OP_ADD);
        #1;
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_grant0 got=%b exp=10", req_ready); end
        tick();
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_grant1 got=%b exp=01", req_ready); end
        tick();
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_stall_ready c=%0d got=%b exp=00", c, req_ready); end
            n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd22 || rsp_id !== 1'b1 || alu_a !== 32'd10) begin n_fail++; $display("FAIL bp_hold c=%0d got=v%b d%0d id%0d a%0d exp=v1 d22 id1 a10", c, rsp_valid, rsp_data, rsp_id, alu_a); end
            if (c < 2) tick();
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd11 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL bp_second got=v%b d%0d id%0d exp=v1 d11 id0", rsp_valid, rsp_data, rsp_id); end
        tick();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_flush();
        rsp_ready = 1'b0;
        req_valid = 2'b00;
        set_req(1, 1'b1, 32'd41, 32'd0, ALU_OP_ADD);
        tick();
        req_valid = 2'b00;
        set_req(0, 1'b1, 32'd30, 32'd0, ALU_OP_ADD);
        tick();
        set_req(0, 1'b1, 32'd31, 32'd0, ALU_OP_ADD);
        rsp_ready = 1'b1;
        flush = 1'b1;
        #1;
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL flush_no_grant got=%b exp=00", req_ready); end
        tick();
        flush = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_rsp_valid got=%b exp=0", rsp_valid); end
        n_checks++; if (rsp_data !== 32'd41 || alu_a !== 32'd30) begin n_fail++; $display("FAIL flush_hold got=d%0d a%0d exp=d41 a30", rsp_data, alu_a); end
        set_req(0, 1'b1, 32'd60, 32'd0, ALU_OP_ADD);
        set_req(1, 1'b1, 32'd50, 32'd0, ALU_OP_ADD);
        #1;
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL flush_ptr_grant got=%b exp=10", req_ready); end
        tick();
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL flush_next_grant got=%b exp=01", req_ready); end
        tick();
        req_valid = 2'b00;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'd50) begin n_fail++; $display("FAIL flush_rsp1 got=v%b id%0d d%0d exp=v1 id1 d50", rsp_valid, rsp_id, rsp_data); end
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd60) begin n_fail++; $display("FAIL flush_rsp2 got=v%b id%0d d%0d exp=v1 id0 d60", rsp_valid, rsp_id, rsp_data); end
        tick();
    endtask

    task automatic test_equal_operands();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 32'h1234, 32'h1234, ALU_OP_SUB);
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL eq_grant0 got=%b exp=01", req_ready); end
        tick();
        set_req(0, 1'b1, 32'd9, 32'd4, ALU_OP_SUB);
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL eq_grant1 got=%b exp=01", req_ready); end
        tick();
        req_valid = 2'b00;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd0 || rsp_zero !== 1'b1) begin n_fail++; $display("FAIL eq_zero got=v%b d%h z%b exp=v1 d0 z1", rsp_valid, rsp_data, rsp_zero); end
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd5 || rsp_zero !== 1'b0) begin n_fail++; $display("FAIL eq_nonzero got=v%b d%0d z%b exp=v1 d5 z0", rsp_valid, rsp_data, rsp_zero); end
        tick();
    endtask

    task automatic test_reset_mid_op();
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 32'd80, 32'd0, ALU_OP_ADD);
        set_req(1, 1'b1, 32'd70, 32'd0, ALU_OP_ADD);
        tick();
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || alu_a !== 32'd80) begin n_fail++; $display("FAIL rst_mid_full got=v%b a%0d exp=v1 a80", rsp_valid, alu_a); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 1'b0 || alu_a !== 32'd0 || rsp_data !== 32'd0) begin n_fail++; $display("FAIL rst_mid_clear got=v%b a%0d d%0d exp=v0 a0 d0", rsp_valid, alu_a, rsp_data); end
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_mid_ready got=%b exp=00", req_ready); end
        #2;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rst_first_grant got=%b exp=01", req_ready); end
        tick();
        req_valid = 2'b00;
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd80 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL rst_first_rsp got=v%b d%0d id%0d exp=v1 d80 id0", rsp_valid, rsp_data, rsp_id); end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_flush();
        test_equal_operands();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
